// File: rtl/grid_pkg.sv
// grid_pkg: shared grid geometry and the tick-sequencer state encoding.
// Holds GRID_W, GRID_H, CELLS, IDX_W, the last-cell index and the state enum.
package grid_pkg;

  localparam int GRID_W = 96;
  localparam int GRID_H = 72;
  localparam int CELLS  = GRID_W * GRID_H;
  localparam int IDX_W  = 13;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SWEEP,
    DRAIN,
    SWAP
  } state_t;

endpackage

// File: rtl/grid_tick_sched_trigger.sv
// tick_trigger: frame divider plus sticky tick-pending latch.
// Ports:
//   clk_in, rst_in  clock, synchronous active-high reset
//   frame_start     one-cycle pulse per display frame
//   run_en          enables automatic ticks; low holds the divider at its start
//   step_req        one-cycle single-tick request
//   consume         scheduler accepted the pending tick
//   pending         a tick is requested and not yet consumed
module tick_trigger #(
  parameter int TICK_FRAMES = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic frame_start,
  input  logic run_en,
  input  logic step_req,
  input  logic consume,
  output logic pending
);

  localparam int FW = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
  localparam logic [FW-1:0] RELOAD = FW'(TICK_FRAMES - 1);

  // Down-counter of frames remaining; reaching 0 on a pulse is the wrap.
  logic [FW-1:0] frames_left;
  logic          wrap;

  assign wrap = run_en && frame_start && (frames_left == '0);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frames_left <= RELOAD;
      pending     <= 1'b0;
    end else begin
      if (!run_en)
        frames_left <= RELOAD;
      else if (frame_start)
        frames_left <= wrap ? RELOAD : frames_left - FW'(1);

      // Consume wins so requests overlapping the accept collapse into it.
      if (consume)
        pending <= 1'b0;
      else if (wrap || step_req)
        pending <= 1'b1;
    end
  end

endmodule

// File: rtl/grid_tick_sched.sv
// grid_tick_sched: sequences one simulation tick of the people grid.
// Optional clear of the write bank (macro GRID_CLEAR_EN), then a valid/ready
// sweep of cell indices 0..CELLS-1 into the mover, a drain wait, and a bank swap.
// Ports:
//   clk_in, rst_in           clock, synchronous active-high reset
//   frame_start, run_en,
//   step_req                 tick triggers (see tick_trigger)
//   cell_idx/valid/ready     index handshake to the mover
//   mover_idle               mover has no outstanding writes
//   clr_addr, clr_we         clear writes into the write bank (data 0)
//   rd_bank                  old-grid bank; write bank is ~rd_bank
//   busy, tick_done,
//   tick_count               status
//
// state | meaning
// IDLE  | waiting for a pending tick
// CLEAR | zeroing write bank, one address per cycle
// SWEEP | offering cell indices to the mover
// DRAIN | waiting for the mover to finish its writes
// SWAP  | toggle banks, count the tick, pulse tick_done
module grid_tick_sched
  import grid_pkg::*;
#(
  parameter int TICK_FRAMES = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             frame_start,
  input  logic             run_en,
  input  logic             step_req,
  output logic [IDX_W-1:0] cell_idx,
  output logic             cell_valid,
  input  logic             cell_ready,
  input  logic             mover_idle,
  output logic [IDX_W-1:0] clr_addr,
  output logic             clr_we,
  output logic             rd_bank,
  output logic             busy,
  output logic             tick_done,
  output logic [15:0]      tick_count
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             pending;
  logic             consume;
  logic             idx_last;

  tick_trigger #(.TICK_FRAMES(TICK_FRAMES)) u_trigger (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .frame_start (frame_start),
    .run_en      (run_en),
    .step_req    (step_req),
    .consume     (consume),
    .pending     (pending)
  );

  // One index counter serves both the clear walk and the sweep.
  assign idx_last = (idx_q == LAST_IDX);
  assign cell_idx = idx_q;
`ifdef GRID_CLEAR_EN
  assign clr_addr = idx_q;
`else
  assign clr_addr = '0;
`endif

  always_comb begin
    state_d    = state_q;
    consume    = 1'b0;
    cell_valid = 1'b0;
    clr_we     = 1'b0;
    tick_done  = 1'b0;
    busy       = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (pending) begin
          consume = 1'b1;
`ifdef GRID_CLEAR_EN
          state_d = CLEAR;
`else
          state_d = SWEEP;
`endif
        end
      end
      CLEAR: begin
`ifdef GRID_CLEAR_EN
        clr_we = 1'b1;
        if (idx_last)
          state_d = SWEEP;
`else
        state_d = IDLE;
`endif
      end
      SWEEP: begin
        cell_valid = 1'b1;
        if (cell_ready && idx_last)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (mover_idle)
          state_d = SWAP;
      end
      SWAP: begin
        tick_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rd_bank    <= 1'b0;
      tick_count <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        CLEAR: idx_q <= idx_last ? '0 : idx_q + IDX_W'(1);
        SWEEP: begin
          if (cell_ready)
            idx_q <= idx_last ? '0 : idx_q + IDX_W'(1);
        end
        SWAP: begin
          rd_bank    <= ~rd_bank;
          tick_count <= tick_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_tick_sched.sv
module tb_grid_tick_sched;
  localparam int CELLS = 6912;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        frame_start;
  logic        run_en;
  logic        step_req;
  logic [12:0] cell_idx;
  logic        cell_valid;
  logic        cell_ready;
  logic        mover_idle;
  logic [12:0] clr_addr;
  logic        clr_we;
  logic        rd_bank;
  logic        busy;
  logic        tick_done;
  logic [15:0] tick_count;

  int ncmp = 0;
  int nerr = 0;
  bit        exp_bank = 1'b0;
  logic [15:0] exp_count = '0;

  grid_tick_sched #(.TICK_FRAMES(4)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .frame_start (frame_start),
    .run_en      (run_en),
    .step_req    (step_req),
    .cell_idx    (cell_idx),
    .cell_valid  (cell_valid),
    .cell_ready  (cell_ready),
    .mover_idle  (mover_idle),
    .clr_addr    (clr_addr),
    .clr_we      (clr_we),
    .rd_bank     (rd_bank),
    .busy        (busy),
    .tick_done   (tick_done),
    .tick_count  (tick_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic start_step();
    step_req = 1'b1;
    step();
    step_req = 1'b0;
    chk("step_busy_lat", busy, 0);
    step();
    chk("step_busy", busy, 1);
  endtask

  // Entered at the negedge of the first busy cycle of a tick.
  task automatic run_tick(input bit rnd, input int idle_delay, input bit inject);
    int q[$];
    int budget;
    bit stall;
    logic [12:0] prev;
    stall = 1'b0;
    prev  = '0;
`ifdef GRID_CLEAR_EN
    for (int k = 0; k < CELLS; k++) begin
      chk("clr_we", clr_we, 1);
      chk("clr_addr", clr_addr, k);
      chk("clr_no_valid", cell_valid, 0);
      step();
    end
`endif
    for (int i = 0; i < CELLS; i++) q.push_back(i);
    mover_idle = (idle_delay == 0);
    budget = 0;
    while (q.size() > 0 && budget < 30000) begin
      budget++;
      step_req = 1'b0;
      chk("sweep_valid", cell_valid, 1);
      chk("sweep_bank", rd_bank, exp_bank);
      chk("sweep_clr_we", clr_we, 0);
      if (stall) chk("stall_hold", cell_idx, prev);
      cell_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (inject && cell_ready && (q.size() == 6000 || q.size() == 4000 || q.size() == 2000))
        step_req = 1'b1;
      if (cell_ready) chk("sweep_idx", cell_idx, q.pop_front());
      stall = !cell_ready;
      prev  = cell_idx;
      step();
    end
    step_req = 1'b0;
    if (q.size() > 0) chk("sweep_timeout", q.size(), 0);
    chk("drain_valid", cell_valid, 0);
    chk("drain_done", tick_done, 0);
    chk("drain_busy", busy, 1);
    for (int d = 0; d < idle_delay; d++) begin
      step();
      chk("drain_wait_done", tick_done, 0);
    end
    mover_idle = 1'b1;
    step();
    chk("tick_done", tick_done, 1);
    chk("swap_bank_old", rd_bank, exp_bank);
    exp_bank  = ~exp_bank;
    exp_count = exp_count + 16'd1;
    step();
    chk("tick_done_pulse", tick_done, 0);
    chk("bank_swapped", rd_bank, exp_bank);
    chk("tick_count", tick_count, exp_count);
    chk("idle_after", busy, 0);
  endtask

  initial begin
    int b;
    rst_in = 1'b1; frame_start = 1'b0; run_en = 1'b0; step_req = 1'b0;
    cell_ready = 1'b0; mover_idle = 1'b1;
    step(); step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", cell_valid, 0);
    chk("rst_idx", cell_idx, 0);
    chk("rst_clr_we", clr_we, 0);
    chk("rst_clr_addr", clr_addr, 0);
    chk("rst_bank", rd_bank, 0);
    chk("rst_done", tick_done, 0);
    chk("rst_count", tick_count, 0);
    rst_in = 1'b0;
    step();
    chk("post_rst_busy", busy, 0);

    // Automatic tick after four frames.
    run_en = 1'b1;
    for (int p = 0; p < 4; p++) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("frame_busy", busy, 0);
      if (p < 3) begin
        step(); step();
        chk("frame_gap_busy", busy, 0);
      end
    end
    run_en = 1'b0;
    step();
    chk("auto_busy", busy, 1);
    run_tick(1'b0, 0, 1'b0);

    // Random back-pressure.
    start_step();
    run_tick(1'b1, 0, 1'b0);

    // Slow mover drain.
    start_step();
    run_tick(1'b0, 50, 1'b0);

    // Step requests during a tick collapse into one follow-on tick.
    start_step();
    run_tick(1'b0, 0, 1'b1);
    step();
    chk("extra_tick_busy", busy, 1);
    run_tick(1'b0, 0, 1'b0);
    chk("two_ticks_count", tick_count, 16'd5);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("no_third_tick", busy, 0);
    end

    // Reset mid-sweep.
    start_step();
    cell_ready = 1'b1;
    b = 0;
    while (!(cell_valid === 1'b1 && cell_idx == 13'd3000) && b < 20000) begin
      step();
      b++;
    end
    chk("reach_3000", cell_idx, 3000);
    rst_in = 1'b1;
    step();
    chk("mrst_idx", cell_idx, 0);
    chk("mrst_valid", cell_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_bank", rd_bank, 0);
    chk("mrst_count", tick_count, 0);
    chk("mrst_done", tick_done, 0);
    chk("mrst_clr_we", clr_we, 0);
    rst_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("mrst_idle_done", tick_done, 0);
      chk("mrst_idle_busy", busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
